// File: rtl/tile_map_blitter_pkg.sv
// Shared types and constants for the tile-map blitter: map geometry, cell
// address arithmetic, register offsets, operation codes and FSM states.
package tile_map_blitter_pkg;

  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;
  localparam int AW       = 12;

  typedef logic [AW-1:0] map_addr_t;
  typedef logic [3:0]    tile_t;
  typedef logic [4:0]    row_t;
  typedef logic [5:0]    col_t;

  typedef enum logic [1:0] {
    BLIT_FILL  = 2'd0,
    BLIT_SHIFT = 2'd1
  } blit_op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_SHIFT_RD = 3'd2,
    ST_SHIFT_WR = 3'd3,
    ST_FILL_TOP = 3'd4,
    ST_DONE     = 3'd5
  } blit_state_t;

  localparam logic [3:0] REG_CTRL = 4'd0;
  localparam logic [3:0] REG_RECT = 4'd1;
  localparam logic [3:0] REG_TILE = 4'd2;

  // row*40+col without a multiplier: 40 = 32 + 8
  function automatic map_addr_t cell_addr(input row_t row, input col_t col);
    cell_addr = (map_addr_t'(row) << 5) + (map_addr_t'(row) << 3) + map_addr_t'(col);
  endfunction

endpackage

// File: rtl/tile_map_blitter_cursor.sv
// Row/column walker for the blitter. Holds the current cell, computes the
// cell that will be current after this clock (load, step or hold) and the
// map addresses of that next cell and of the cell directly above it.
module tile_map_blitter_cursor
  import tile_map_blitter_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  row_t      load_row,
  input  col_t      load_col,
  input  logic      step,
  input  logic      dir_down,
  input  col_t      col_first,
  input  col_t      col_last,
  input  row_t      row_last,
  output map_addr_t addr_next,
  output map_addr_t addr_up_next,
  output logic      last_cell
);

  row_t row;
  col_t col;
  row_t row_next;
  col_t col_next;

  // Next position: load wins, otherwise step along the row and wrap to the next row
  always_comb begin
    row_next = row;
    col_next = col;
    if (load) begin
      row_next = load_row;
      col_next = load_col;
    end else if (step) begin
      if (col == col_last) begin
        col_next = col_first;
        row_next = dir_down ? row - 5'd1 : row + 5'd1;
      end else begin
        col_next = col + 6'd1;
      end
    end
  end

  assign last_cell    = (col == col_last) && (row == row_last);
  assign addr_next    = cell_addr(row_next, col_next);
  assign addr_up_next = cell_addr(row_next - 5'd1, col_next);

  // Position register
  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_next;
      col <= col_next;
    end
  end

endmodule

// File: rtl/tile_map_blitter.sv
// Tile-map blitter: a small register file on the iomem bus plus an engine that
// fills a rectangle of the 40x30 tile map with one tile, or shifts a rectangle
// down by one row (reading through a private port) and refills its top row.
module tile_map_blitter
  import tile_map_blitter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          bus_valid,
  output logic          bus_ready,
  input  logic [3:0]    bus_wstrb,
  input  logic [3:0]    bus_addr,
  input  logic [31:0]   bus_wdata,
  output logic [31:0]   bus_rdata,
  output logic          map_wen,
  output logic [AW-1:0] map_waddr,
  output logic [3:0]    map_wdata,
  output logic          map_ren,
  output logic [AW-1:0] map_raddr,
  input  logic [3:0]    map_rdata,
  output logic          busy,
  output logic          done
);

  col_t        rect_x0;
  col_t        rect_w;
  row_t        rect_y0;
  row_t        rect_h;
  tile_t       tile_reg;
  logic        error;
  blit_state_t state;
  tile_t       wdata_q;
  logic        wdata_from_ram;

  logic        bus_acc;
  logic        bus_wr;
  logic        bus_rd;
  logic        ctrl_wr;
  logic [1:0]  req_op;
  logic [6:0]  x_end;
  logic [5:0]  y_end;
  logic        start_ok;
  logic        start_is_fill;
  logic [31:0] rect_word;

  logic        cur_load;
  row_t        cur_load_row;
  logic        cur_step;
  logic        cur_dir_down;
  col_t        cur_col_last;
  row_t        cur_row_last;
  map_addr_t   cur_addr_next;
  map_addr_t   cur_addr_up_next;
  logic        cur_last_cell;

  logic        unused_wdata_bits;

  assign unused_wdata_bits = ^{bus_wdata[31:29], bus_wdata[23:21], bus_wdata[15:14], bus_wdata[7:6]};

  assign bus_acc = bus_valid && !bus_ready;
  assign bus_wr  = bus_acc && (bus_wstrb != 4'd0);
  assign bus_rd  = bus_acc && (bus_wstrb == 4'd0);
  assign ctrl_wr = bus_wr && (bus_addr == REG_CTRL);
  assign req_op  = bus_wdata[1:0];

  assign rect_word = {3'b0, rect_h, 3'b0, rect_y0, 2'b0, rect_w, 2'b0, rect_x0};

  // Rectangle must be non-empty and lie entirely inside the map
  assign x_end         = {1'b0, rect_x0} + {1'b0, rect_w};
  assign y_end         = {1'b0, rect_y0} + {1'b0, rect_h};
  assign start_is_fill = (req_op == BLIT_FILL);
  assign start_ok      = (req_op[1] == 1'b0)
                      && (rect_w != 6'd0) && (rect_h != 5'd0)
                      && (x_end <= 7'(MAP_COLS)) && (y_end <= 6'(MAP_ROWS));

  // Shifted-row data is forwarded straight from the read port in SHIFT_WR
  assign map_wdata = wdata_from_ram ? map_rdata : wdata_q;

  assign cur_col_last = rect_x0 + rect_w - 6'd1;

  // Cursor control: load at a legal start, step through cells while writing
  always_comb begin
    cur_load     = 1'b0;
    cur_load_row = rect_y0;
    cur_step     = 1'b0;
    cur_dir_down = (state != ST_FILL);
    cur_row_last = rect_y0;
    case (state)
      ST_FILL:                  cur_row_last = rect_y0 + rect_h - 5'd1;
      ST_SHIFT_RD, ST_SHIFT_WR: cur_row_last = rect_y0 + 5'd1;
      default:                  cur_row_last = rect_y0;
    endcase
    if (ctrl_wr && !busy && start_ok) begin
      cur_load = 1'b1;
      if (!start_is_fill && (rect_h != 5'd1)) begin
        cur_load_row = rect_y0 + rect_h - 5'd1;
      end
    end else if ((state == ST_FILL) || (state == ST_SHIFT_WR) || (state == ST_FILL_TOP)) begin
      cur_step = 1'b1;
    end
  end

  tile_map_blitter_cursor u_cursor (
    .clk          (clk),
    .reset        (reset),
    .load         (cur_load),
    .load_row     (cur_load_row),
    .load_col     (rect_x0),
    .step         (cur_step),
    .dir_down     (cur_dir_down),
    .col_first    (rect_x0),
    .col_last     (cur_col_last),
    .row_last     (cur_row_last),
    .addr_next    (cur_addr_next),
    .addr_up_next (cur_addr_up_next),
    .last_cell    (cur_last_cell)
  );

  // Register file and bus handshake; RECT/TILE are frozen while an op runs
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      rect_x0   <= '0;
      rect_w    <= '0;
      rect_y0   <= '0;
      rect_h    <= '0;
      tile_reg  <= '0;
    end else begin
      bus_ready <= bus_acc;
      bus_rdata <= '0;
      if (bus_rd) begin
        case (bus_addr)
          REG_CTRL: bus_rdata <= {30'b0, error, busy};
          REG_RECT: bus_rdata <= rect_word;
          REG_TILE: bus_rdata <= {28'b0, tile_reg};
          default:  bus_rdata <= '0;
        endcase
      end
      if (bus_wr && !busy) begin
        if (bus_addr == REG_RECT) begin
          rect_h  <= bus_wdata[28:24];
          rect_y0 <= bus_wdata[20:16];
          rect_w  <= bus_wdata[13:8];
          rect_x0 <= bus_wdata[5:0];
        end
        if (bus_addr == REG_TILE) begin
          tile_reg <= bus_wdata[3:0];
        end
      end
    end
  end

  // Operation FSM with registered RAM-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      map_wen        <= 1'b0;
      map_ren        <= 1'b0;
      map_waddr      <= '0;
      map_raddr      <= '0;
      wdata_q        <= '0;
      wdata_from_ram <= 1'b0;
    end else begin
      done           <= 1'b0;
      map_wen        <= 1'b0;
      map_ren        <= 1'b0;
      wdata_from_ram <= 1'b0;
      if (ctrl_wr && busy) begin
        error <= 1'b1;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (ctrl_wr) begin
            if (!start_ok) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              error   <= 1'b0;
              busy    <= 1'b1;
              wdata_q <= tile_reg;
              if (start_is_fill || (rect_h == 5'd1)) begin
                state     <= start_is_fill ? ST_FILL : ST_FILL_TOP;
                map_wen   <= 1'b1;
                map_waddr <= cur_addr_next;
              end else begin
                state     <= ST_SHIFT_RD;
                map_ren   <= 1'b1;
                map_raddr <= cur_addr_up_next;
              end
            end
          end
        end
        ST_FILL, ST_FILL_TOP: begin
          if (cur_last_cell) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            map_wen   <= 1'b1;
            map_waddr <= cur_addr_next;
          end
        end
        ST_SHIFT_RD: begin
          state          <= ST_SHIFT_WR;
          map_wen        <= 1'b1;
          map_waddr      <= cur_addr_next;
          wdata_from_ram <= 1'b1;
        end
        ST_SHIFT_WR: begin
          if (cur_last_cell) begin
            state     <= ST_FILL_TOP;
            map_wen   <= 1'b1;
            map_waddr <= cur_addr_next;
          end else begin
            state     <= ST_SHIFT_RD;
            map_ren   <= 1'b1;
            map_raddr <= cur_addr_up_next;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_map_blitter.sv
// Bench for tile_map_blitter: map RAM model with 1-cycle read latency, a
// reference model that derives the per-cycle RAM traffic and resulting map
// contents from the rectangle rules, and directed plus random operations.
module tb_tile_map_blitter;
  import tile_map_blitter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_valid;
  logic        bus_ready;
  logic [3:0]  bus_wstrb;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        map_wen;
  logic [11:0] map_waddr;
  logic [3:0]  map_wdata;
  logic        map_ren;
  logic [11:0] map_raddr;
  logic [3:0]  map_rdata;
  logic        busy;
  logic        done;

  logic        pl_en;
  logic [11:0] pl_addr;
  logic [3:0]  pl_data;
  logic [3:0]  ram [0:4095];

  typedef struct {
    bit is_wr;
    int addr;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  ref_mem [1200];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  tile_map_blitter dut (
    .clk       (clk),
    .reset     (reset),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_wstrb (bus_wstrb),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .map_wen   (map_wen),
    .map_waddr (map_waddr),
    .map_wdata (map_wdata),
    .map_ren   (map_ren),
    .map_raddr (map_raddr),
    .map_rdata (map_rdata),
    .busy      (busy),
    .done      (done)
  );

  // Map RAM: synchronous write, registered read
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (map_wen) ram[map_waddr] <= map_wdata;
    if (map_ren) map_rdata <= ram[map_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rect_word(input int x0, input int w, input int y0, input int h);
    return {3'b0, 5'(h), 3'b0, 5'(y0), 2'b0, 6'(w), 2'b0, 6'(x0)};
  endfunction

  // Ends on the negedge of the cycle in which bus_ready is high
  task automatic bus_access(input logic [3:0] a, input logic [31:0] d, input bit wr,
                            output logic [31:0] rd);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_wstrb = wr ? 4'hf : 4'h0;
    bus_addr  = a;
    bus_wdata = d;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus_ready) break;
    end
    check("bus_ack", 32'(bus_ready), 32'd1);
    rd        = bus_rdata;
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_access(a, d, 1'b1, dummy);
  endtask

  task automatic bus_read_check(input string tag, input logic [3:0] a, input logic [31:0] expv);
    logic [31:0] rd;
    bus_access(a, 32'd0, 1'b0, rd);
    check(tag, rd, expv);
  endtask

  // Reference: RAM traffic and resulting map contents from the rectangle rules
  task automatic model_op(input int op, input int x0, input int w, input int y0, input int h,
                          input int tile, output bit legal);
    exp_q.delete();
    legal = (op == 0 || op == 1) && w > 0 && h > 0 && x0 + w <= 40 && y0 + h <= 30;
    if (!legal) return;
    if (op == 0) begin
      for (int r = y0; r < y0 + h; r++)
        for (int c = x0; c < x0 + w; c++) begin
          exp_q.push_back('{1'b1, r * 40 + c, tile});
          ref_mem[r * 40 + c] = tile;
        end
    end else begin
      for (int r = y0 + h - 1; r > y0; r--)
        for (int c = x0; c < x0 + w; c++) begin
          exp_q.push_back('{1'b0, (r - 1) * 40 + c, 0});
          exp_q.push_back('{1'b1, r * 40 + c, ref_mem[(r - 1) * 40 + c]});
          ref_mem[r * 40 + c] = ref_mem[(r - 1) * 40 + c];
        end
      for (int c = x0; c < x0 + w; c++) begin
        exp_q.push_back('{1'b1, y0 * 40 + c, tile});
        ref_mem[y0 * 40 + c] = tile;
      end
    end
  endtask

  // Starts on the cycle after the CTRL write was accepted
  task automatic check_events(input string tag);
    logic [31:0] obs;
    logic [31:0] expv;
    for (int i = 0; i <= exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (i < exp_q.size()) begin
        obs  = {13'b0, busy, map_wen, map_ren, map_wen ? map_waddr : map_raddr,
                map_wen ? map_wdata : 4'h0};
        expv = {13'b0, 1'b1, exp_q[i].is_wr, ~exp_q[i].is_wr, 12'(exp_q[i].addr),
                exp_q[i].is_wr ? 4'(exp_q[i].data) : 4'h0};
        check({tag, "/cell"}, obs, expv);
      end else begin
        check({tag, "/done"}, {28'b0, done, busy, map_wen, map_ren}, 32'b1000);
      end
    end
  endtask

  task automatic run_op(input string tag, input int op, input int x0, input int w, input int y0,
                        input int h, input int tile, output bit legal);
    bus_write(REG_RECT, rect_word(x0, w, y0, h));
    bus_write(REG_TILE, 32'(tile));
    model_op(op, x0, w, y0, h, tile, legal);
    bus_write(REG_CTRL, 32'(op));
    check_events(tag);
  endtask

  initial begin
    bit legal;
    int op, x0, w, y0, h, tile;

    reset     = 1'b1;
    bus_valid = 1'b0;
    bus_wstrb = 4'h0;
    bus_addr  = 4'h0;
    bus_wdata = 32'h0;
    pl_en     = 1'b0;
    pl_addr   = 12'h0;
    pl_data   = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {27'b0, busy, done, map_wen, map_ren, bus_ready}, 32'd0);
    check("rst_addr", {8'b0, map_waddr, map_raddr}, 32'd0);
    check("rst_data", {28'b0, map_wdata}, 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    reset = 1'b0;
    bus_read_check("rst_rect", REG_RECT, 32'd0);
    bus_read_check("rst_tile", REG_TILE, 32'd0);
    bus_read_check("rst_status", REG_CTRL, 32'd0);

    // Whole-map fill
    run_op("full", 0, 0, 40, 0, 30, 9, legal);
    bus_read_check("full_status", REG_CTRL, 32'd0);

    // Random map contents
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 12'(i);
      pl_data = 4'($urandom);
      ref_mem[i] = int'(pl_data);
    end
    @(negedge clk);
    pl_en = 1'b0;

    run_op("fill_ex", 0, 1, 2, 2, 3, 5, legal);
    bus_read_check("fill_ex_tile", REG_TILE, 32'd5);
    bus_read_check("fill_ex_rect", REG_RECT, rect_word(1, 2, 2, 3));

    run_op("setA", 0, 0, 1, 0, 1, 10, legal);
    run_op("setB", 0, 0, 1, 1, 1, 11, legal);
    run_op("setC", 0, 0, 1, 2, 1, 12, legal);
    run_op("shift_ex", 1, 0, 1, 0, 3, 0, legal);
    run_op("shift_h1", 1, 5, 3, 7, 1, 6, legal);

    run_op("ill_xw", 0, 39, 2, 0, 1, 3, legal);
    bus_read_check("ill_xw_status", REG_CTRL, 32'h2);
    run_op("ill_op", 2, 0, 1, 0, 1, 3, legal);
    bus_read_check("ill_op_status", REG_CTRL, 32'h2);
    run_op("ill_yh", 1, 0, 1, 28, 3, 3, legal);
    bus_read_check("ill_yh_status", REG_CTRL, 32'h2);
    run_op("clr_err", 0, 3, 1, 3, 1, 4, legal);
    bus_read_check("clr_err_status", REG_CTRL, 32'h0);

    // CTRL and RECT writes while busy
    bus_write(REG_RECT, rect_word(2, 5, 3, 4));
    bus_write(REG_TILE, 32'd7);
    model_op(0, 2, 5, 3, 4, 7, legal);
    bus_write(REG_CTRL, 32'd0);
    fork
      check_events("busy_ctrl");
      begin
        repeat (3) @(posedge clk);
        bus_write(REG_CTRL, 32'd1);
        bus_write(REG_RECT, rect_word(0, 1, 0, 1));
      end
    join
    bus_read_check("busy_status", REG_CTRL, 32'h2);
    bus_read_check("busy_rect", REG_RECT, rect_word(2, 5, 3, 4));
    run_op("after_busy", 1, 10, 4, 20, 3, 2, legal);
    bus_read_check("after_busy_status", REG_CTRL, 32'h0);

    // Random operations
    for (int n = 0; n < 30; n++) begin
      op   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      x0   = $urandom_range(0, 39);
      w    = $urandom_range(0, 8);
      y0   = $urandom_range(0, 29);
      h    = $urandom_range(1, 6);
      tile = $urandom_range(0, 15);
      run_op("rand", op, x0, w, y0, h, tile, legal);
      bus_read_check("rand_status", REG_CTRL, legal ? 32'h0 : 32'h2);
    end

    for (int i = 0; i < 1200; i++) begin
      check("map_contents", {28'b0, ram[i]}, 32'(ref_mem[i]));
    end

    // Reset in the middle of a shift
    bus_write(REG_RECT, rect_word(0, 10, 5, 6));
    bus_write(REG_CTRL, 32'd1);
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", {28'b0, map_wen, map_ren, busy, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_outs", {28'b0, map_wen, map_ren, busy, done}, 32'd0);
    bus_read_check("post_rst_status", REG_CTRL, 32'h0);
    bus_read_check("post_rst_rect", REG_RECT, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
